// File: rtl/uart_rx_if.sv
// Ready/valid byte channel between the UART receive front end and its consumer.
interface uart_rx_if;
    logic [7:0] data_out;
    logic       data_out_valid;
    logic       data_out_ready;

    modport master (
        output data_out,
        output data_out_valid,
        input  data_out_ready
    );

    modport slave (
        input  data_out,
        input  data_out_valid,
        output data_out_ready
    );
endinterface

// File: rtl/uart_rx_frontend.sv
// 8N1 UART receiver: line synchroniser, deframing FSM and a one-entry byte buffer
// with ready/valid output, framing-error pulse and sticky overrun flag.
module uart_rx_frontend #(
    parameter int unsigned CLOCK_FREQ = 50_000_000,
    parameter int unsigned BAUD_RATE  = 115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       serial_in,
    uart_rx_if.master  rx,
    output logic       framing_error,
    output logic       overrun,
    input  logic       overrun_clear,
    output logic       rx_busy
);

    localparam int unsigned SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE;
    localparam int unsigned SAMPLE_TIME      = SYMBOL_EDGE_TIME / 2;
    localparam int unsigned CNT_W            = (SYMBOL_EDGE_TIME > 1) ? $clog2(SYMBOL_EDGE_TIME) : 1;
    localparam logic [CNT_W-1:0] SYMBOL_LAST = CNT_W'(SYMBOL_EDGE_TIME - 1);
    localparam logic [CNT_W-1:0] SAMPLE_LAST = CNT_W'(SAMPLE_TIME - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } state_t;

    state_t           state;
    logic             sync1;
    logic             line_s;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_cnt;
    logic [7:0]       shreg;
    logic             transfer_c;

    assign transfer_c = rx.data_out_valid && rx.data_out_ready;

    // Two-flop synchroniser; reset to the idle (high) line level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1  <= 1'b1;
            line_s <= 1'b1;
        end else begin
            sync1  <= serial_in;
            line_s <= sync1;
        end
    end

    // Deframing FSM with the output buffer; later assignments override earlier ones,
    // so a commit beats a same-cycle transfer and an overrun set beats a clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state             <= IDLE;
            cnt               <= '0;
            bit_cnt           <= '0;
            shreg             <= '0;
            rx.data_out       <= '0;
            rx.data_out_valid <= 1'b0;
            framing_error     <= 1'b0;
            overrun           <= 1'b0;
            rx_busy           <= 1'b0;
        end else begin
            framing_error <= 1'b0;
            if (overrun_clear) overrun <= 1'b0;
            if (transfer_c) rx.data_out_valid <= 1'b0;

            case (state)
                IDLE: begin
                    cnt     <= '0;
                    bit_cnt <= '0;
                    if (!line_s) begin
                        state   <= START;
                        rx_busy <= 1'b1;
                    end
                end
                START: begin
                    if (cnt == SAMPLE_LAST) begin
                        cnt <= '0;
                        if (!line_s) begin
                            state <= DATA;
                        end else begin
                            state   <= IDLE;
                            rx_busy <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt == SYMBOL_LAST) begin
                        cnt     <= '0;
                        shreg   <= {line_s, shreg[7:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == 3'd7) state <= STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (cnt == SYMBOL_LAST) begin
                        cnt <= '0;
                        if (line_s) begin
                            if (!rx.data_out_valid || transfer_c) begin
                                rx.data_out       <= shreg;
                                rx.data_out_valid <= 1'b1;
                            end else begin
                                overrun <= 1'b1;
                            end
                            state   <= IDLE;
                            rx_busy <= 1'b0;
                        end else begin
                            framing_error <= 1'b1;
                            state         <= WAIT_HIGH;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WAIT_HIGH: begin
                    cnt <= '0;
                    if (line_s) begin
                        state   <= IDLE;
                        rx_busy <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    cnt     <= '0;
                    rx_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_frontend.sv
// Directed bench for uart_rx_frontend at 10 clocks per bit.
`timescale 1ns/1ps
module tb_uart_rx_frontend;

    logic clk;
    logic rst;
    logic serial_in;
    logic framing_error;
    logic overrun;
    logic overrun_clear;
    logic rx_busy;

    uart_rx_if u_if ();

    uart_rx_frontend #(
        .CLOCK_FREQ (1_000_000),
        .BAUD_RATE  (100_000)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .serial_in     (serial_in),
        .rx            (u_if),
        .framing_error (framing_error),
        .overrun       (overrun),
        .overrun_clear (overrun_clear),
        .rx_busy       (rx_busy)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int fe_cnt   = 0;
    int rise_cyc = -1;
    int t0       = 0;
    logic valid_q = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Count framing-error cycles and remember when valid last rose.
    always @(negedge clk) begin
        if (framing_error === 1'b1) fe_cnt = fe_cnt + 1;
        if (u_if.data_out_valid === 1'b1 && valid_q !== 1'b1) rise_cyc = cyc;
        valid_q = u_if.data_out_valid;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    // One frame, one iteration per clock; rdy_at pulses ready on that iteration,
    // abort_at asserts rst at that iteration and stops.
    task automatic send_frame(input logic [7:0] b, input int stop_len, input logic stop_val,
                              input int rdy_at, input int abort_at);
        logic [9:0] fr;
        fr = {stop_val, b, 1'b0};
        for (int i = 0; i < 90 + stop_len; i++) begin
            tick();
            if (i == 0) t0 = cyc;
            if (i == abort_at) begin
                rst = 1'b1;
                return;
            end
            serial_in = (i < 90) ? fr[i / 10] : stop_val;
            if (rdy_at >= 0) u_if.data_out_ready = (i == rdy_at);
        end
        tick();
        serial_in = 1'b1;
    endtask

    task automatic consume();
        u_if.data_out_ready = 1'b1;
        tick();
        u_if.data_out_ready = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int fe_base;
        int lat;
        rst                 = 1'b1;
        serial_in           = 1'b1;
        overrun_clear       = 1'b0;
        u_if.data_out_ready = 1'b0;
        idle(3);
        check_eq("rst_data",    32'(u_if.data_out), 32'h0);
        check_eq("rst_valid",   32'(u_if.data_out_valid), 32'h0);
        check_eq("rst_fe",      32'(framing_error), 32'h0);
        check_eq("rst_overrun", 32'(overrun), 32'h0);
        check_eq("rst_busy",    32'(rx_busy), 32'h0);
        rst = 1'b0;
        idle(5);

        // Basic frame and latency
        send_frame(8'hA5, 10, 1'b1, -1, -1);
        lat = rise_cyc - t0;
        check_eq("a5_latency_96_98", 32'(lat >= 96 && lat <= 98), 32'h1);
        check_eq("a5_data",  32'(u_if.data_out), 32'hA5);
        check_eq("a5_valid", 32'(u_if.data_out_valid), 32'h1);
        check_eq("a5_no_fe", 32'(fe_cnt), 32'h0);
        check_eq("a5_busy",  32'(rx_busy), 32'h0);
        consume();
        check_eq("a5_consumed", 32'(u_if.data_out_valid), 32'h0);
        idle(3);

        // Overrun: second byte dropped while first pending
        send_frame(8'h3C, 10, 1'b1, -1, -1);
        idle(3);
        check_eq("ovr_first_valid", 32'(u_if.data_out_valid), 32'h1);
        check_eq("ovr_first_clear", 32'(overrun), 32'h0);
        send_frame(8'h81, 10, 1'b1, -1, -1);
        idle(2);
        check_eq("ovr_set",   32'(overrun), 32'h1);
        check_eq("ovr_data",  32'(u_if.data_out), 32'h3C);
        check_eq("ovr_valid", 32'(u_if.data_out_valid), 32'h1);
        overrun_clear = 1'b1;
        tick();
        overrun_clear = 1'b0;
        check_eq("ovr_cleared", 32'(overrun), 32'h0);
        consume();
        check_eq("ovr_valid_drop", 32'(u_if.data_out_valid), 32'h0);
        idle(3);

        // Commit coincident with a transfer replaces the byte without overrun
        send_frame(8'h55, 10, 1'b1, -1, -1);
        idle(2);
        check_eq("p55_data", 32'(u_if.data_out), 32'h55);
        send_frame(8'hF0, 10, 1'b1, 97, -1);
        check_eq("f0_valid",   32'(u_if.data_out_valid), 32'h1);
        check_eq("f0_data",    32'(u_if.data_out), 32'hF0);
        check_eq("f0_overrun", 32'(overrun), 32'h0);
        consume();
        idle(3);

        // Short low glitch
        fe_base = fe_cnt;
        serial_in = 1'b0;
        idle(3);
        serial_in = 1'b1;
        idle(2);
        check_eq("glitch_busy", 32'(rx_busy), 32'h1);
        idle(10);
        check_eq("glitch_idle",  32'(rx_busy), 32'h0);
        check_eq("glitch_valid", 32'(u_if.data_out_valid), 32'h0);
        check_eq("glitch_no_fe", 32'(fe_cnt - fe_base), 32'h0);

        // Framing error with a 40-cycle low stop bit
        send_frame(8'h12, 40, 1'b0, -1, -1);
        check_eq("fe_pulse_once", 32'(fe_cnt - fe_base), 32'h1);
        check_eq("fe_valid",      32'(u_if.data_out_valid), 32'h0);
        check_eq("fe_wait_busy",  32'(rx_busy), 32'h1);
        idle(5);
        check_eq("fe_back_idle",  32'(rx_busy), 32'h0);
        send_frame(8'h34, 10, 1'b1, -1, -1);
        idle(2);
        check_eq("after_fe_data",  32'(u_if.data_out), 32'h34);
        check_eq("after_fe_valid", 32'(u_if.data_out_valid), 32'h1);
        check_eq("after_fe_no_fe", 32'(fe_cnt - fe_base), 32'h1);

        // Reset mid-frame with a byte pending and overrun set
        send_frame(8'h77, 10, 1'b1, -1, -1);
        idle(2);
        check_eq("pre_rst_overrun", 32'(overrun), 32'h1);
        send_frame(8'h99, 10, 1'b1, -1, 50);
        #1;
        check_eq("midrst_data",    32'(u_if.data_out), 32'h0);
        check_eq("midrst_valid",   32'(u_if.data_out_valid), 32'h0);
        check_eq("midrst_overrun", 32'(overrun), 32'h0);
        check_eq("midrst_busy",    32'(rx_busy), 32'h0);
        check_eq("midrst_fe",      32'(framing_error), 32'h0);
        serial_in = 1'b1;
        idle(2);
        rst = 1'b0;
        idle(5);
        fe_base = fe_cnt;
        send_frame(8'h99, 10, 1'b1, -1, -1);
        idle(2);
        check_eq("post_rst_data",  32'(u_if.data_out), 32'h99);
        check_eq("post_rst_valid", 32'(u_if.data_out_valid), 32'h1);
        check_eq("post_rst_no_fe", 32'(fe_cnt - fe_base), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
